// File: rtl/line_seq_pkg.sv
// Shared types and constants for the multi-row line input sequencer.
// The optional stall port (LINE_SEQ_STALL_EN) is handled in the interface and top.
package line_seq_pkg;
  localparam int X_MAC      = 4;
  localparam int X_MESH     = 16;
  localparam int BUFFER_NUM = X_MAC * X_MESH;
  localparam int ADDR_LEN   = 13;
  localparam int MUXCONTROL = 4;
  localparam int MAX_ROWS   = 4;
  localparam int ROW_W      = $clog2(MAX_ROWS + 1);
  localparam int LEN_W      = 12;

  localparam int CTL_LOAD  = 0;
  localparam int CTL_SHIFT = 1;
  localparam int CTL_PAD   = 2;
  localparam int CTL_LAST  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LPAD,
    BODY,
    RPAD,
    DRAIN
  } seq_state_e;

  typedef struct packed {
    logic                  valid;
    logic [MUXCONTROL-1:0] ctl;
    logic [3:0]            iszero;
  } ctl_t;

  // Columns actually read from the body: every word, or every other word rounded up.
  function automatic logic [LEN_W-1:0] body_len(input logic [LEN_W-1:0] linelen,
                                                input logic stride2);
    logic [LEN_W:0] rounded;
    rounded = {1'b0, linelen} + (LEN_W+1)'(1);
    return stride2 ? LEN_W'(rounded >> 1) : linelen;
  endfunction
endpackage

// File: rtl/line_input_sequencer_if.sv
// Scheduler <-> line sequencer bus; the stall input exists only with LINE_SEQ_STALL_EN.
interface line_input_sequencer_if;
  import line_seq_pkg::*;

  // start is a one-cycle request sampled only while idle. An accepted request raises busy the
  // next cycle, and busy stays high through the one-cycle done pulse; a rejected request pulses
  // cfg_err instead and busy stays low. out_valid qualifies control_out/iszero; no backpressure.
  logic                           start;
  logic [ADDR_LEN-1:0]            st_addr;
  logic [ADDR_LEN-1:0]            row_pitch;
  logic [LEN_W-1:0]               linelen;
  logic [ROW_W-1:0]               num_rows;
  logic [1:0]                     pad_w;
  logic                           stride2;
`ifdef LINE_SEQ_STALL_EN
  logic                           stall;
`endif
  logic [BUFFER_NUM*ADDR_LEN-1:0] addrb;
  logic [MUXCONTROL-1:0]          control_out;
  logic [3:0]                     iszero;
  logic                           out_valid;
  logic                           busy;
  logic                           done;
  logic                           cfg_err;

  modport master (
`ifdef LINE_SEQ_STALL_EN
    output stall,
`endif
    output start, st_addr, row_pitch, linelen, num_rows, pad_w, stride2,
    input  addrb, control_out, iszero, out_valid, busy, done, cfg_err
  );

  modport slave (
`ifdef LINE_SEQ_STALL_EN
    input  stall,
`endif
    input  start, st_addr, row_pitch, linelen, num_rows, pad_w, stride2,
    output addrb, control_out, iszero, out_valid, busy, done, cfg_err
  );
endinterface

// File: rtl/line_seq_delay.sv
// Fixed-depth register pipe that aligns issue-side control with BufferPool read data.
module line_seq_delay
  import line_seq_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  ctl_t d,
  output ctl_t q
);
  ctl_t pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/line_input_sequencer.sv
// Multi-row line input sequencer: walks left pad / body / right pad columns over num_rows rows,
// issuing BufferPool reads with RD_LAT-aligned control. LINE_SEQ_STALL_EN adds a stall input.
module line_input_sequencer
  import line_seq_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  line_input_sequencer_if.slave bus,
  output seq_state_e            state_dbg
);
  seq_state_e          state_q, state_d;
  logic [LEN_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    rows_q, rows_d;
  logic [ADDR_LEN-1:0] base_q, base_d;
  logic [ADDR_LEN-1:0] pitch_q, addr_q, addr_cur, issue_addr;
  logic [LEN_W-1:0]    body_q, body_in;
  logic [1:0]          pad_q;
  logic                stride2_q;
  logic                done_q, done_d, err_q, err_d;
  logic                stall, idle, reject, accept;
  logic                issue, first_col, last_col, pad_col, row_end;
  logic [LEN_W:0]      eff_len;
  ctl_t                issue_ctl, out_ctl;

`ifdef LINE_SEQ_STALL_EN
  assign stall = bus.stall;
`else
  assign stall = 1'b0;
`endif

  assign body_in = body_len(bus.linelen, bus.stride2);
  assign eff_len = {1'b0, body_in} + (LEN_W+1)'({bus.pad_w, 1'b0});
  assign reject  = (bus.num_rows == '0) || (bus.num_rows > ROW_W'(MAX_ROWS)) ||
                   (eff_len < (LEN_W+1)'(4));
  // The done cycle still counts as busy, so a start there is dropped.
  assign idle    = (state_q == IDLE) && !done_q;
  assign accept  = idle && bus.start && !reject;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      rows_q    <= '0;
      base_q    <= '0;
      pitch_q   <= '0;
      body_q    <= '0;
      pad_q     <= '0;
      stride2_q <= 1'b0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
      base_q  <= base_d;
      addr_q  <= addr_cur;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        pitch_q   <= bus.row_pitch;
        body_q    <= body_in;
        pad_q     <= bus.pad_w;
        stride2_q <= bus.stride2;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    rows_d     = rows_q;
    base_d     = base_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    issue      = 1'b0;
    first_col  = 1'b0;
    last_col   = 1'b0;
    pad_col    = 1'b0;
    row_end    = 1'b0;
    issue_addr = base_q;

    case (state_q)
      IDLE: begin
        if (idle && bus.start) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = (bus.pad_w != 2'd0) ? LPAD : BODY;
            col_d   = '0;
            rows_d  = bus.num_rows;
            base_d  = bus.st_addr;
          end
        end
      end
      LPAD: begin
        if (!stall) begin
          issue     = 1'b1;
          pad_col   = 1'b1;
          first_col = (col_q == '0);
          if (col_q == LEN_W'(pad_q) - LEN_W'(1)) begin
            col_d   = '0;
            // An empty body (linelen 0) goes straight to the right pad.
            state_d = (body_q != '0) ? BODY : RPAD;
          end else begin
            col_d = col_q + LEN_W'(1);
          end
        end
      end
      BODY: begin
        if (!stall) begin
          issue      = 1'b1;
          issue_addr = base_q + (ADDR_LEN'(col_q) << stride2_q);
          first_col  = (pad_q == 2'd0) && (col_q == '0);
          if (col_q == body_q - LEN_W'(1)) begin
            col_d = '0;
            if (pad_q != 2'd0) begin
              state_d = RPAD;
            end else begin
              last_col = 1'b1;
              row_end  = 1'b1;
            end
          end else begin
            col_d = col_q + LEN_W'(1);
          end
        end
      end
      RPAD: begin
        if (!stall) begin
          issue   = 1'b1;
          pad_col = 1'b1;
          if (col_q == LEN_W'(pad_q) - LEN_W'(1)) begin
            col_d    = '0;
            last_col = 1'b1;
            row_end  = 1'b1;
          end else begin
            col_d = col_q + LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (col_q == LEN_W'(RD_LAT - 1)) begin
            col_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            col_d = col_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Rows run back to back: the next row's first column issues on the very next cycle.
    if (row_end) begin
      if (rows_q == ROW_W'(1)) begin
        state_d = DRAIN;
      end else begin
        rows_d  = rows_q - ROW_W'(1);
        base_d  = base_q + pitch_q;
        state_d = (pad_q != 2'd0) ? LPAD : BODY;
      end
    end
  end

  assign addr_cur  = issue ? issue_addr : addr_q;
  assign bus.addrb = {BUFFER_NUM{addr_cur}};

  always_comb begin
    issue_ctl                = '0;
    issue_ctl.valid          = issue;
    issue_ctl.ctl[CTL_LOAD]  = first_col;
    issue_ctl.ctl[CTL_SHIFT] = issue && !first_col && !last_col;
    issue_ctl.ctl[CTL_PAD]   = pad_col;
    issue_ctl.ctl[CTL_LAST]  = last_col;
    issue_ctl.iszero         = {4{pad_col}};
  end

  line_seq_delay #(.DEPTH(RD_LAT)) u_delay (
    .clk (clk),
    .rst (rst),
    .d   (issue_ctl),
    .q   (out_ctl)
  );

  assign bus.out_valid   = out_ctl.valid;
  assign bus.control_out = out_ctl.ctl;
  assign bus.iszero      = out_ctl.iszero;
  assign bus.busy        = (state_q != IDLE) || done_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = err_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_line_input_sequencer.sv
// Scoreboard bench for line_input_sequencer: a column-list reference model feeds an expected
// queue, and a negedge monitor compares every out_valid beat plus done alignment.
module tb_line_input_sequencer;
  import line_seq_pkg::*;

  localparam int RD_LAT = 1;
  localparam int IW     = ADDR_LEN + MUXCONTROL + 4;
  localparam int AMASK  = (1 << ADDR_LEN) - 1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  seq_state_e state_dbg;

  line_input_sequencer_if bus();

  line_input_sequencer #(.RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int                  vectors     = 0;
  int                  miscompares = 0;
  int                  accepted    = 0;
  int                  done_seen   = 0;
  bit                  stall_rand  = 1'b0;
  logic [IW-1:0]       exp_q[$];
  logic [ADDR_LEN-1:0] hist[$];
  logic                prev_ov = 1'b0;
  logic [IW-1:0]       item;

  task automatic check(input string name, input longint actual, input longint required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, required, $time);
    end
  endtask

  // Reference model: each row is a flat list of columns (left pad, body, right pad).
  task automatic build_exp(input int st, input int pitch, input int len, input int rows,
                           input int pad, input bit s2, output bit rej);
    int body, ncol, base, addr;
    bit is_pad, load, last, shift;
    body = s2 ? (len + 1) / 2 : len;
    rej  = (rows == 0) || (rows > MAX_ROWS) || (body + 2 * pad < 4);
    if (rej) return;
    ncol = body + 2 * pad;
    for (int r = 0; r < rows; r++) begin
      base = (st + r * pitch) & AMASK;
      for (int c = 0; c < ncol; c++) begin
        is_pad = (c < pad) || (c >= pad + body);
        addr   = is_pad ? base : ((base + (c - pad) * (s2 ? 2 : 1)) & AMASK);
        load   = (c == 0);
        last   = (c == ncol - 1);
        shift  = !load && !last;
        exp_q.push_back({ADDR_LEN'(addr), last, is_pad, shift, load, {4{is_pad}}});
      end
    end
    accepted++;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
        hist.delete();
        for (int i = 0; i <= RD_LAT; i++) hist.push_back('0);
      end else begin
        hist.push_front(bus.addrb[ADDR_LEN-1:0]);
        void'(hist.pop_back());
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL extra_beat: out_valid with ctl %0h, no beat expected at %0t",
                     bus.control_out, $time);
          end else begin
            item = exp_q.pop_front();
            check("beat", {hist[RD_LAT], bus.control_out, bus.iszero}, item);
          end
          begin
            bit same = 1'b1;
            for (int b = 1; b < BUFFER_NUM; b++)
              if (bus.addrb[b*ADDR_LEN +: ADDR_LEN] != bus.addrb[ADDR_LEN-1:0]) same = 1'b0;
            check("bank_copies", same, 1);
          end
        end else begin
          check("idle_ctl_zero", {bus.control_out, bus.iszero}, 0);
        end
        if (bus.done) begin
          done_seen++;
`ifdef LINE_SEQ_STALL_EN
          check("done_drained", exp_q.size(), 0);
`else
          check("done_align", {prev_ov, exp_q.size() == 0}, 2'b11);
`endif
        end
        prev_ov = bus.out_valid;
      end
    end
  end

`ifdef LINE_SEQ_STALL_EN
  initial begin
    bus.stall = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.stall = stall_rand && ($urandom_range(0, 5) == 0);
    end
  end
`endif

  // ---------------- driver ----------------
  task automatic run_pass(input int st, input int pitch, input int len, input int rows,
                          input int pad, input bit s2);
    bit rej;
    int n;
    build_exp(st, pitch, len, rows, pad, s2, rej);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.st_addr   = ADDR_LEN'(st);
    bus.row_pitch = ADDR_LEN'(pitch);
    bus.linelen   = LEN_W'(len);
    bus.num_rows  = ROW_W'(rows);
    bus.pad_w     = 2'(pad);
    bus.stride2   = s2;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.st_addr   = ADDR_LEN'($urandom);
    bus.row_pitch = ADDR_LEN'($urandom);
    bus.linelen   = LEN_W'($urandom);
    bus.num_rows  = ROW_W'($urandom);
    @(negedge clk);
    check("cfg_err", bus.cfg_err, rej);
    check("busy_after_start", bus.busy, !rej);
    if (rej) begin
      repeat (3) @(negedge clk);
      check("reject_stays_idle", {bus.busy, bus.cfg_err}, 0);
      return;
    end
    if (!stall_rand) begin
      check("latency_ov_low", bus.out_valid, 0);
      for (int c = 2; c <= RD_LAT; c++) begin
        @(negedge clk);
        check("latency_ov_low", bus.out_valid, 0);
      end
      @(negedge clk);
      check("first_out_valid", bus.out_valid, 1);
    end
    // A start while busy must be ignored.
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles, busy=%0b", n, bus.busy);
    end else begin
      check("busy_in_done", bus.busy, 1);
    end
    @(negedge clk);
    check("busy_after_done", bus.busy, 0);
  endtask

  task automatic reset_mid_pass();
    bit rej;
    build_exp(100, 64, 20, 2, 2, 1'b0, rej);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.st_addr   = ADDR_LEN'(100);
    bus.row_pitch = ADDR_LEN'(64);
    bus.linelen   = LEN_W'(20);
    bus.num_rows  = ROW_W'(2);
    bus.pad_w     = 2'd2;
    bus.stride2   = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_ctl", {bus.control_out, bus.iszero}, 0);
    check("rst_flags", {bus.busy, bus.done, bus.cfg_err}, 0);
    check("rst_addrb", bus.addrb[ADDR_LEN-1:0], 0);
    check("rst_state", state_dbg, IDLE);
    exp_q.delete();
    accepted--;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("no_done_after_abort", {bus.done, bus.busy}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start     = 1'b0;
    bus.st_addr   = '0;
    bus.row_pitch = '0;
    bus.linelen   = '0;
    bus.num_rows  = '0;
    bus.pad_w     = '0;
    bus.stride2   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", state_dbg, IDLE);
    check("reset_outputs", {bus.out_valid, bus.busy, bus.done, bus.cfg_err, bus.control_out}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_pass(0, 0, 9, 1, 1, 1'b0);
    run_pass(0, 16, 9, 3, 1, 1'b0);
    run_pass(0, 0, 9, 1, 0, 1'b1);
    run_pass(0, 0, 1, 1, 1, 1'b0);
    run_pass(0, 0, 9, 0, 1, 1'b0);
    run_pass(0, 0, 9, 5, 0, 1'b0);
    run_pass(8190, 0, 4, 1, 0, 1'b0);
    run_pass(40, 8, 0, 2, 2, 1'b0);
    run_pass(8000, 4000, 7, 4, 3, 1'b1);
    reset_mid_pass();
    run_pass(0, 16, 9, 3, 1, 1'b0);

`ifdef LINE_SEQ_STALL_EN
    stall_rand = 1'b1;
`endif
    for (int t = 0; t < 40; t++) begin
      run_pass(int'($urandom_range(0, AMASK)), int'($urandom_range(0, AMASK)),
               int'($urandom_range(0, 24)), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end
    stall_rand = 1'b0;

    repeat (5) @(negedge clk);
    check("done_count", done_seen, accepted);
    check("leftover_beats", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
